spi_master_param: RTL and testbench

- Parametrised full-duplex SPI master. Successor to the fixed 8-bit, three-slave master.
- Generates SCLK from the system clock through a programmable divider.
- Supports all four SPI modes. The mode is latched per transfer.
- Drives NUM_SLAVES active-low chip selects and exchanges a DATA_WIDTH-bit word with a start/busy/done handshake.
- Sits between a local controller (register bank or testbench) and the off-block SPI slaves.

---
 rtl/spi_master_param_if.sv | 28 ++
 rtl/spi_master_param.sv | 113 +++++++++++
 tb/tb_spi_master_param.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_param_if.sv
// spi_master_param_if: control handshake and SPI pins between a local controller and spi_master_param
interface spi_master_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 3,
    parameter int SEL_W      = $clog2(NUM_SLAVES + 1)
);
    logic                  start;
    logic [1:0]            mode;
    logic [SEL_W-1:0]      cs_sel;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic [NUM_SLAVES-1:0] cs_n;

    modport master (
        input  start, mode, cs_sel, tx_data, miso,
        output rx_data, busy, done, sclk, mosi, cs_n
    );

    modport slave (
        output start, mode, cs_sel, tx_data, miso,
        input  rx_data, busy, done, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master with programmable SCLK divider and all four modes
module spi_master_param #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 3,
    parameter int CLK_DIV    = 2,
    parameter bit LSB_FIRST  = 1'b0,
    parameter int SEL_W      = $clog2(NUM_SLAVES + 1)
) (
    input logic                clk,
    input logic                reset,
    spi_master_param_if.master bus
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * DATA_WIDTH);
    localparam logic [CW-1:0]    DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [EW-1:0]    EDGE_LAST = EW'(2 * DATA_WIDTH - 1);
    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(NUM_SLAVES);
    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

    state_t                state, next_state;
    logic [CW-1:0]         div_cnt;
    logic [EW-1:0]         edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_data;
    logic [SEL_W-1:0]      sel;
    logic [NUM_SLAVES-1:0] cs_n;
    logic                  cpha, sclk, mosi, done, busy;
    logic                  accept, tick, last_edge, lead_edge, sample, shift;

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v, input logic b);
        return LSB_FIRST ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
    endfunction

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_WIDTH-1];
    endfunction

    assign accept    = bus.start && bus.cs_sel != '0 && bus.cs_sel <= SEL_MAX;
    assign tick      = state != IDLE && div_cnt == DIV_LAST;
    assign last_edge = edge_cnt == EDGE_LAST;
    assign lead_edge = ~edge_cnt[0];
    // CPHA=0 samples on leading edges and shifts on trailing ones; CPHA=1 is the mirror image
    assign sample    = cpha ^ lead_edge;
    assign shift     = cpha ? lead_edge : ~lead_edge && ~last_edge;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? LEAD : IDLE;
            LEAD:    next_state = tick ? XFER : LEAD;
            XFER:    next_state = (tick && last_edge) ? TRAIL : XFER;
            TRAIL:   next_state = tick ? GAP : TRAIL;
            GAP:     next_state = tick ? IDLE : GAP;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
        cs_n = '1;
        if (state inside {LEAD, XFER, TRAIL}) cs_n = ~(NUM_SLAVES'(1) << (sel - SEL_ONE));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            sel      <= '0;
            cpha     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            done     <= 1'b0;
        end else begin
            div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + CW'(1);
            done    <= state == TRAIL && tick;
            if (state == TRAIL && tick) rx_data <= rx_sr;
            // sclk tracks CPOL while idle so the level is settled before CS asserts
            if (state == IDLE) begin
                sclk     <= bus.mode[1];
                edge_cnt <= '0;
                if (accept) begin
                    cpha  <= bus.mode[0];
                    sel   <= bus.cs_sel;
                    tx_sr <= bus.mode[0] ? bus.tx_data : shift_in(bus.tx_data, 1'b0);
                    if (!bus.mode[0]) mosi <= first_bit(bus.tx_data);
                end
            end else if (state == XFER && tick) begin
                sclk     <= ~sclk;
                edge_cnt <= edge_cnt + EW'(1);
                if (sample) rx_sr <= shift_in(rx_sr, bus.miso);
                if (shift) begin
                    mosi  <= first_bit(tx_sr);
                    tx_sr <= shift_in(tx_sr, 1'b0);
                end
            end
        end
    end

    assign bus.rx_data = rx_data;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.sclk    = sclk;
    assign bus.mosi    = mosi;
    assign bus.cs_n    = cs_n;
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: MSB-first and LSB-first masters in lockstep against a behavioural SPI slave
module tb_spi_master_param;
    localparam int W  = 8;
    localparam int NS = 3;
    localparam int D  = 2;
    localparam int SW = $clog2(NS + 1);
    localparam int P  = (2 * W + 3) * D + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, loopback = 1'b0;
    logic [1:0]    mode = '0, cur_mode = '0;
    logic [SW-1:0] sel = '0;
    logic [W-1:0]  tx = '0, sw = '0, cap_m, cap_l;
    logic          slv_m = 1'b0, slv_l = 1'b0, cs_act;
    int            si, rises, edges, n_tests, n_fail;

    spi_master_param_if #(.DATA_WIDTH(W), .NUM_SLAVES(NS)) bm ();
    spi_master_param_if #(.DATA_WIDTH(W), .NUM_SLAVES(NS)) bl ();

    spi_master_param #(.DATA_WIDTH(W), .NUM_SLAVES(NS), .CLK_DIV(D), .LSB_FIRST(1'b0))
        u_dut (.clk(clk), .reset(reset), .bus(bm.master));
    spi_master_param #(.DATA_WIDTH(W), .NUM_SLAVES(NS), .CLK_DIV(D), .LSB_FIRST(1'b1))
        u_lsb (.clk(clk), .reset(reset), .bus(bl.master));

    assign bm.start = start;
    assign bl.start = start;
    assign bm.mode = mode;
    assign bl.mode = mode;
    assign bm.cs_sel = sel;
    assign bl.cs_sel = sel;
    assign bm.tx_data = tx;
    assign bl.tx_data = tx;
    assign bm.miso = loopback ? bm.mosi : slv_m;
    assign bl.miso = loopback ? bl.mosi : slv_l;
    assign cs_act = ~&bm.cs_n;

    // Slave: word sw goes out MSB-first to u_dut and LSB-first to u_lsb, mosi is captured the same way
    task automatic present(input int i);
        if (i < W) begin
            slv_m = sw[W-1-i];
            slv_l = sw[i];
        end
    endtask

    always @(posedge cs_act) begin
        si = 0;
        cap_m = '0;
        cap_l = '0;
        if (!cur_mode[0]) present(0);
    end

    always @(bm.sclk) begin
        edges++;
        if (bm.sclk) rises++;
        if (cs_act) begin
            if ((bm.sclk != cur_mode[1]) ^ cur_mode[0]) begin
                cap_m = {cap_m[W-2:0], bm.mosi};
                cap_l = {bl.mosi, cap_l[W-1:1]};
            end else if (cur_mode[0]) begin
                present(si);
                si++;
            end else begin
                si++;
                present(si);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [1:0] m, input logic [SW-1:0] s, input logic [W-1:0] t,
                        input logic [W-1:0] w, input logic lb);
        int n, dn, bn, nd;
        logic [NS-1:0] cs_exp, cs_obs;
        @(negedge clk);
        mode = m; sel = s; tx = t; sw = w; cur_mode = m; loopback = lb; start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 0;
        cs_exp = ~(NS'(1) << (s - 1));
        cs_obs = '1;
        n = 1; dn = 0; bn = 0; nd = 0;
        check("sclk_idle_pre", bm.sclk, m[1]);
        check("busy_rise", bm.busy, 1);
        while (bn == 0 && n < 400) begin
            if (bm.cs_n != '1 && cs_obs == '1) cs_obs = bm.cs_n;
            if (bm.cs_n != '1 && bm.cs_n != cs_exp) cs_obs = bm.cs_n;
            if (bm.done) begin
                nd++;
                if (dn == 0) dn = n;
            end
            if (!bm.busy) bn = n;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("cs_n", cs_obs, cs_exp);
        check("done_at", dn, (2 * W + 2) * D + 1);
        check("done_width", nd, 1);
        check("busy_fall", bn, P);
        check("sclk_rises", rises, W);
        check("sclk_idle_post", bm.sclk, m[1]);
        check("rx_msb", bm.rx_data, lb ? t : w);
        check("rx_lsb", bl.rx_data, lb ? t : w);
        check("mosi_msb", cap_m, t);
        check("mosi_lsb", cap_l, t);
    endtask

    task automatic ignored(input logic [SW-1:0] s);
        int bad;
        @(negedge clk);
        mode = 2'd0; cur_mode = 2'd0; sel = s;
        @(negedge clk);
        start = 1'b1;
        edges = 0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bm.busy || bl.busy || bm.cs_n != '1) bad++;
        end
        start = 1'b0;
        check("ign_busy_cs", bad, 0);
        check("ign_cs_n", bm.cs_n, 3'b111);
        check("ign_sclk_edges", edges, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, nd, gap, k;
        bit seen_low;
        logic [W-1:0] exp_q[$];
        n_tests = 0;
        n_fail = 0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", bm.cs_n, 3'b111);
        check("rst_sclk", bm.sclk, 0);
        check("rst_mosi", bm.mosi, 0);
        check("rst_busy", bm.busy, 0);
        check("rst_done", bm.done, 0);
        check("rst_rx", bm.rx_data, 0);
        reset = 1'b1;
        xfer(2'd0, 2'd1, 8'hA5, 8'h00, 1'b1);
        for (int m = 1; m < 4; m++) xfer(m[1:0], 2'd2, 8'h5A, 8'h3C, 1'b0);
        xfer(2'd0, 2'd3, 8'h01, 8'h80, 1'b0);
        for (int i = 0; i < 12; i++)
            xfer(2'($urandom_range(0, 3)), SW'($urandom_range(1, NS)), W'($urandom), W'($urandom), 1'b0);
        ignored(2'd0);
        ignored(SW'(NS + 1));
        xfer(2'd0, 2'd1, 8'hB6, 8'h7E, 1'b0);
        // Abort mid-transfer at the 5th sclk edge
        @(negedge clk);
        mode = 2'd0; cur_mode = 2'd0; sel = 2'd1; tx = 8'hC3; sw = 8'h5A; loopback = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        n = 0;
        while (edges < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_edge", edges, 5);
        reset = 1'b0;
        #1;
        check("abort_cs_n", bm.cs_n, 3'b111);
        check("abort_sclk", bm.sclk, 0);
        check("abort_busy", bm.busy, 0);
        check("abort_rx", bm.rx_data, 0);
        nd = 0;
        repeat (4) begin
            @(negedge clk);
            if (bm.done || bl.done) nd++;
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bm.done || bl.done) nd++;
        end
        check("abort_no_done", nd, 0);
        xfer(2'd1, 2'd2, 8'h3E, 8'hD4, 1'b0);
        // Back-to-back with start held high and tx toggling every cycle
        @(negedge clk);
        mode = 2'd0; cur_mode = 2'd0; sel = 2'd2; loopback = 1'b1;
        @(negedge clk);
        nd = 0; gap = 0; seen_low = 1'b0;
        for (k = 0; k < 3 * P; k++) begin
            tx = (k % 2 == 1) ? 8'h00 : 8'hFF;
            start = 1'b1;
            if (k % P == 0) exp_q.push_back(tx);
            @(negedge clk);
            if (bm.done) begin
                nd++;
                check("b2b_rx_msb", bm.rx_data, exp_q.size() > 0 ? exp_q[0] : 8'hxx);
                check("b2b_rx_lsb", bl.rx_data, exp_q.size() > 0 ? exp_q[0] : 8'hxx);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (bm.cs_n == '1) gap++;
            else begin
                if (gap > 0 && seen_low) check("b2b_cs_gap", gap, D + 1);
                gap = 0;
                seen_low = 1'b1;
            end
        end
        start = 1'b0;
        check("b2b_dones", nd, 3);
        repeat (5) @(negedge clk);
        check("b2b_idle", bm.busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
